// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding and default sizes.
package dmem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF     = 10;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;
  // Starvation counter width; covers STARVE_MAX up to 15.
  localparam int unsigned STARVE_CNT_W   = 4;

  typedef enum logic {
    ARB_SHARED = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_rd_capture.sv
// Per-requester read response: one-cycle rvalid flop and a hold register that
// keeps the last returned word visible after rvalid drops.
module dmem_arbiter_rd_capture #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_issue_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_c_o
);

  logic              rvalid_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] hold_d;

  always_comb begin
    hold_d = hold_q;
    if (rvalid_q) begin
      hold_d = mem_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      rvalid_q <= rd_issue_i;
      hold_q   <= hold_d;
    end
  end

  assign rvalid_o  = rvalid_q;
  // Pass-through while valid, otherwise the captured word.
  assign rdata_c_o = hold_d;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU load/store stage and the
// debug/loader port: CPU priority, debug starvation guard, debug lock mode.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_locked,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_ena,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [STARVE_CNT_W-1:0] StarveMax = STARVE_CNT_W'(STARVE_MAX);

  arb_state_e              state_q;
  arb_state_e              state_d;
  logic [STARVE_CNT_W-1:0] starve_q;
  logic [STARVE_CNT_W-1:0] starve_d;
  logic                    locked;
  logic                    dbg_win;
  logic                    cpu_gnt;
  logic                    cpu_rd_issue;
  logic                    dbg_rd_issue;

  assign locked = (state_q == ARB_LOCKED);

  // Next state, arbitration and memory-port mux.
  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    dbg_win      = 1'b0;
    cpu_gnt      = 1'b0;
    cpu_stall    = 1'b0;
    dbg_gnt      = 1'b0;
    mem_ena      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    cpu_rd_issue = 1'b0;
    dbg_rd_issue = 1'b0;

    unique case (state_q)
      ARB_SHARED: if (dbg_lock)  state_d = ARB_LOCKED;
      ARB_LOCKED: if (!dbg_lock) state_d = ARB_SHARED;
      default:                   state_d = ARB_SHARED;
    endcase

    dbg_win   = dbg_req & (locked | ~cpu_req | (starve_q == StarveMax));
    cpu_gnt   = cpu_req & ~dbg_win & ~locked;
    dbg_gnt   = dbg_win;
    cpu_stall = cpu_req & ~cpu_gnt;

    if (dbg_req && !dbg_win) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + STARVE_CNT_W'(1);
    end else begin
      starve_d = '0;
    end

    if (dbg_win) begin
      mem_ena      = 1'b1;
      mem_we       = dbg_we;
      mem_addr     = dbg_addr;
      mem_wdata    = dbg_wdata;
      dbg_rd_issue = ~dbg_we;
    end else if (cpu_gnt) begin
      mem_ena      = 1'b1;
      mem_we       = cpu_we;
      mem_addr     = cpu_addr;
      mem_wdata    = cpu_wdata;
      cpu_rd_issue = ~cpu_we;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB_SHARED;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign dbg_locked = locked;

  dmem_arbiter_rd_capture #(.DATA_W(DATA_W)) u_cpu_rd (
    .clk         (clk),
    .rst         (rst),
    .rd_issue_i  (cpu_rd_issue),
    .mem_rdata_i (mem_rdata),
    .rvalid_o    (cpu_rvalid),
    .rdata_c_o   (cpu_rdata)
  );

  dmem_arbiter_rd_capture #(.DATA_W(DATA_W)) u_dbg_rd (
    .clk         (clk),
    .rst         (rst),
    .rd_issue_i  (dbg_rd_issue),
    .mem_rdata_i (mem_rdata),
    .rvalid_o    (dbg_rvalid),
    .rdata_c_o   (dbg_rdata)
  );

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 32-bit x 1024-word data memory BRAM between two requesters:
  - the CPU datapath (load/store stage);
  - a debug/loader port, used for program/data load and memory inspection.
- Fixed CPU priority, with a starvation guard for the debug port.
- An optional debug lock mode gives the debug port exclusive ownership and stalls the CPU.
- Sits between the core's memory-access logic and the BRAM instance. Generates the CPU stall request and per-requester read-valid/read-data.

Parameters:
- ADDR_W, 10, word-address width (memory depth 2^ADDR_W words)
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive denied debug-request cycles after which debug wins arbitration (1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request (level, held while stalled)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address (byte address >> 2)
- cpu_wdata  in  DATA_W  CPU write data
- cpu_stall  out  1  CPU request present but not granted this cycle
- cpu_rvalid  out  1  CPU read data valid (cycle after granted read)
- cpu_rdata  out  DATA_W  CPU read data
- dbg_req  in  1  debug access request
- dbg_we  in  1  1 = write
- dbg_addr  in  ADDR_W  debug word address
- dbg_wdata  in  DATA_W  debug write data
- dbg_lock  in  1  request exclusive memory ownership
- dbg_gnt  out  1  debug request granted this cycle
- dbg_locked  out  1  arbiter in LOCKED state
- dbg_rvalid  out  1  debug read data valid
- dbg_rdata  out  DATA_W  debug read data
- mem_ena  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_W  BRAM address
- mem_wdata  out  DATA_W  BRAM write data
- mem_rdata  in  DATA_W  BRAM read data (one-cycle synchronous latency)

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = SHARED, starve_cnt = 0;
  - cpu_rvalid = dbg_rvalid = 0;
  - both rdata capture registers = 0;
  - dbg_locked = 0.
  - Pending read responses are discarded.
- FSM states SHARED and LOCKED:
  - SHARED -> LOCKED at a clock edge with dbg_lock = 1.
  - LOCKED -> SHARED at a clock edge with dbg_lock = 0.
  - dbg_locked = (state == LOCKED), registered.
- Arbitration is combinational and evaluated each cycle:
  - dbg_win = dbg_req & (LOCKED | ~cpu_req | starve_cnt == STARVE_MAX)
  - dbg_gnt = dbg_win
  - cpu_gnt = cpu_req & ~dbg_win & ~LOCKED
  - cpu_stall = cpu_req & ~cpu_gnt (in LOCKED, cpu_stall = cpu_req)
- Memory drive:
  - mem_ena = cpu_gnt | dbg_gnt.
  - mem_we/mem_addr/mem_wdata are muxed from the granted requester.
  - With no grant, mem_we = 0 and addr/wdata = 0.
  - One access issues per cycle, back-to-back without bubbles.
- starve_cnt:
  - increments (saturating at STARVE_MAX) when dbg_req & ~dbg_gnt;
  - clears when dbg_gnt or ~dbg_req.
- Read response:
  - A granted read sets that requester's rvalid flop for exactly the next cycle.
  - During rvalid, rdata = mem_rdata (pass-through) and the value is captured.
  - Otherwise, rdata holds the last captured value.
- Writes:
  - complete at the grant edge;
  - produce no rvalid;
  - leave the capture register unchanged.
- Write-then-read to the same address on consecutive cycles returns the new data (BRAM write-first). No forwarding in the arbiter.
- Simultaneous cases:
  - cpu and dbg both requesting, starve_cnt < STARVE_MAX -> CPU granted.
  - starve_cnt == STARVE_MAX -> debug granted, CPU stalled one cycle.
- dbg_lock asserted in the same cycle as a CPU grant: that CPU access completes; LOCKED applies from the next cycle.
- An outstanding CPU rvalid still delivers in LOCKED.

Decomposition:
- Shared package holds:
  - state encoding (ARB_SHARED = 1'b0, ARB_LOCKED = 1'b1);
  - default widths (ADDR_W = 10, DATA_W = 32);
  - STARVE_MAX default.
- One natural sub-module, rd_capture: rvalid flop plus hold register. Instantiated once per requester.

Test Plan:
- Reset, then CPU write 0xDEADBEEF @0x010, then CPU read @0x010 -> mem_we = 1 in cycle 1; cpu_rvalid = 1 two edges later with cpu_rdata = 0xDEADBEEF; cpu_stall = 0 throughout.
- cpu_req and dbg_req held continuously (reads), STARVE_MAX = 4 -> CPU granted 4 cycles, debug granted on the 5th (cpu_stall = 1 that cycle), pattern repeats.
- dbg_lock = 1 with cpu_req held -> dbg_locked = 1 next edge; cpu_stall = 1 every cycle; debug write 0x12345678 @0x3FF granted; dbg_lock = 0 -> CPU resumes next cycle.
- Debug read @0x3FF, then 5 idle cycles -> dbg_rvalid single-cycle pulse; dbg_rdata = 0x12345678 held across idle cycles.
- Assert rst low mid-read (the cycle after grant) -> cpu_rvalid = 0 immediately; all outputs 0; state SHARED after release.
- Alternating CPU write/read same address every cycle for 16 cycles -> each read returns the preceding write value; no stall, mem_ena = 1 every cycle.
